// File: rtl/alu_result_stage.sv
// alu_result_stage: writeback stage behind the 64-bit ALU.
// Classifies exceptions, buffers up to two results in order and retires them
// to the register file. It also keeps the NZCV status register and a
// saturating count of retired exceptions.
module alu_result_stage #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_c,
    input  logic              in_fz,
    input  logic              in_fc,
    input  logic              in_fn,
    input  logic              in_fv,
    input  logic [2:0]        in_opcode,
    input  logic              in_b_zero,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_setf,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_we,
    output logic [1:0]        wb_exc,
    output logic [3:0]        nzcv_q,
    output logic [CNT_W-1:0]  exc_count
);

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [1:0] EXC_DIVZ    = 2'b10;
    localparam logic [2:0] OP_DIV      = 3'd3;

    // Two-entry skid buffer, one slot per pointer value.
    logic [DATA_W-1:0] data_mem [2];
    logic [RD_W-1:0]   rd_mem   [2];
    logic [1:0]        exc_mem  [2];
    logic [3:0]        flag_mem [2];   // {N,Z,C,V}
    logic              setf_mem [2];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] cls_data;
    logic [1:0]        cls_exc;

    // in_ready looks only at local state, never at wb_ready.
    assign in_ready = !rst && (count < 2'd2);
    assign wb_valid = (count != 2'd0);
    assign push     = in_valid && in_ready;
    assign pop      = wb_valid && wb_ready;

    // Exception classification of the incoming result.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        cls_exc  = EXC_NONE;
        cls_data = in_c;
        if (in_opcode > OP_DIV) begin
            cls_exc  = EXC_ILLEGAL;
            cls_data = '0;
        end else if (in_opcode == OP_DIV && in_b_zero) begin
            cls_exc  = EXC_DIVZ;
            cls_data = '1;
        end
    end

    // Entry storage, written at the tail slot on push.
    // NOTE: the payload array has no reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            data_mem[wr_ptr] <= cls_data;
            rd_mem[wr_ptr]   <= in_rd;
            exc_mem[wr_ptr]  <= cls_exc;
            flag_mem[wr_ptr] <= {in_fn, in_fz, in_fc, in_fv};
            setf_mem[wr_ptr] <= in_setf;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Architectural status and exception counter, updated when the head retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv_q    <= 4'b0000;
            exc_count <= '0;
        end else if (pop) begin
            if (exc_mem[rd_ptr] == EXC_NONE) begin
                if (setf_mem[rd_ptr]) nzcv_q <= flag_mem[rd_ptr];
            end else if (exc_count != {CNT_W{1'b1}}) begin
                exc_count <= exc_count + CNT_W'(1);
            end
        end
    end

    assign wb_data = data_mem[rd_ptr];
    assign wb_rd   = rd_mem[rd_ptr];
    assign wb_exc  = exc_mem[rd_ptr];
    assign wb_we   = (wb_exc == EXC_NONE);

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed tables and sequences, then random
// traffic checked every cycle against a queue-based reference model.
module tb_alu_result_stage;

    localparam int DATA_W = 64;
    localparam int RD_W   = 5;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_c;
    logic              in_fz, in_fc, in_fn, in_fv;
    logic [2:0]        in_opcode;
    logic              in_b_zero;
    logic [RD_W-1:0]   in_rd;
    logic              in_setf;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic              wb_we;
    logic [1:0]        wb_exc;
    logic [3:0]        nzcv_q;
    logic [CNT_W-1:0]  exc_count;

    alu_result_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c),
        .in_fz(in_fz), .in_fc(in_fc), .in_fn(in_fn), .in_fv(in_fv),
        .in_opcode(in_opcode), .in_b_zero(in_b_zero), .in_rd(in_rd), .in_setf(in_setf),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_we(wb_we), .wb_exc(wb_exc), .nzcv_q(nzcv_q), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
        logic [1:0]        exc;
        logic [3:0]        flags;   // {N,Z,C,V}
        logic              setf;
    } ent_t;

    typedef struct {
        logic [2:0]        op;
        logic              bz;
        logic [DATA_W-1:0] c;
        logic [1:0]        exp_exc;
        logic [DATA_W-1:0] exp_data;
        logic              exp_we;
    } vec_t;

    ent_t       mq[$];
    logic [3:0] m_nzcv;
    int         m_cnt;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic bz,
                         input logic [63:0] c, input logic [4:0] rd,
                         input logic setf, input logic [3:0] nzcv);
        in_valid  = v;
        in_opcode = op;
        in_b_zero = bz;
        in_c      = c;
        in_rd     = rd;
        in_setf   = setf;
        {in_fn, in_fz, in_fc, in_fv} = nzcv;
    endtask

    // Result the stage should record for a given instruction.
    function automatic ent_t classify();
        ent_t e;
        e.rd    = in_rd;
        e.flags = {in_fn, in_fz, in_fc, in_fv};
        e.setf  = in_setf;
        if (in_opcode >= 4) begin
            e.exc = 2'b01; e.data = '0;
        end else if (in_opcode == 3 && in_b_zero) begin
            e.exc = 2'b10; e.data = '1;
        end else begin
            e.exc = 2'b00; e.data = in_c;
        end
        return e;
    endfunction

    // One clock: compare DUT against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic do_push, do_pop, exp_ready;
        ent_t e_in, e_out;
        @(negedge clk);
        exp_ready = !rst && (mq.size() < 2);
        check("in_ready", in_ready, exp_ready);
        check("wb_valid", wb_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("wb_data", wb_data, mq[0].data);
            check("wb_rd",   wb_rd,   mq[0].rd);
            check("wb_exc",  wb_exc,  mq[0].exc);
            check("wb_we",   wb_we,   mq[0].exc == 2'b00);
        end
        check("nzcv_q",    nzcv_q,    m_nzcv);
        check("exc_count", exc_count, m_cnt);
        do_push = in_valid && exp_ready;
        do_pop  = (mq.size() != 0) && wb_ready;
        e_in    = classify();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_nzcv = 4'b0000;
            m_cnt  = 0;
        end else begin
            if (do_pop) begin
                e_out = mq.pop_front();
                if (e_out.exc == 2'b00) begin
                    if (e_out.setf) m_nzcv = e_out.flags;
                end else if (m_cnt < (1 << CNT_W) - 1) begin
                    m_cnt++;
                end
            end
            if (do_push) mq.push_back(e_in);
        end
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'd0, 1'b0, 64'd123,                  2'b00, 64'd123,                  1'b1};
        vecs[1] = '{3'd1, 1'b1, 64'hDEAD_BEEF_0000_0001, 2'b00, 64'hDEAD_BEEF_0000_0001, 1'b1};
        vecs[2] = '{3'd2, 1'b1, 64'h8000_0000_0000_0000, 2'b00, 64'h8000_0000_0000_0000, 1'b1};
        vecs[3] = '{3'd3, 1'b0, 64'd7,                    2'b00, 64'd7,                    1'b1};
        vecs[4] = '{3'd3, 1'b1, 64'd7,                    2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[5] = '{3'd4, 1'b0, 64'h1234,                 2'b01, 64'd0,                    1'b0};
        vecs[6] = '{3'd7, 1'b1, 64'h5555,                 2'b01, 64'd0,                    1'b0};
        vecs[7] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'd0,                    1'b0};

        // Reset with in_valid high for two cycles, then idle.
        rst = 1'b1; wb_ready = 1'b1;
        drive(1'b1, 3'd0, 1'b0, 64'h99, 5'd1, 1'b1, 4'b1111);
        @(posedge clk); #1;
        mq.delete(); m_nzcv = 4'b0000; m_cnt = 0;
        check("rst_in_ready", in_ready, 1'b0);
        cycle();
        rst = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 64'h0, 5'd0, 1'b0, 4'b0000);
        cycle();
        check("idle_wb_valid",  wb_valid,  1'b0);
        check("idle_in_ready",  in_ready,  1'b1);
        check("idle_nzcv",      nzcv_q,    4'b0000);
        check("idle_exc_count", exc_count, 2'd0);

        // Single ADD, then a Z/C-flag result that sets NZCV on retire.
        drive(1'b1, 3'd0, 1'b0, 64'h5, 5'd3, 1'b1, 4'b0000);
        cycle();
        check("add_valid", wb_valid, 1'b1);
        check("add_data",  wb_data,  64'h5);
        check("add_rd",    wb_rd,    5'd3);
        check("add_we",    wb_we,    1'b1);
        check("add_exc",   wb_exc,   2'b00);
        drive(1'b1, 3'd0, 1'b0, 64'h0, 5'd4, 1'b1, 4'b0110);
        cycle();
        drive(1'b0, 3'd0, 1'b0, 64'h0, 5'd0, 1'b0, 4'b0000);
        cycle();
        check("flags_nzcv", nzcv_q, 4'b0110);

        // Back-pressure: A, B fill the buffer, C waits upstream.
        wb_ready = 1'b0;
        drive(1'b1, 3'd0, 1'b0, 64'hA, 5'd10, 1'b0, 4'b1001);
        cycle();
        drive(1'b1, 3'd1, 1'b0, 64'hB, 5'd11, 1'b0, 4'b1001);
        cycle();
        drive(1'b1, 3'd2, 1'b0, 64'hC, 5'd12, 1'b0, 4'b1001);
        check("bp_full_ready", in_ready, 1'b0);
        cycle();
        check("bp_hold_head", wb_data, 64'hA);
        wb_ready = 1'b1;
        cycle();
        check("bp_second",   wb_data,  64'hB);
        check("bp_ready_c",  in_ready, 1'b1);
        cycle();
        drive(1'b0, 3'd0, 1'b0, 64'h0, 5'd0, 1'b0, 4'b0000);
        check("bp_third",    wb_data,  64'hC);
        check("bp_third_rd", wb_rd,    5'd12);
        cycle();
        check("bp_drained",  wb_valid, 1'b0);

        // Divide by zero leaves NZCV alone and counts.
        drive(1'b1, 3'd3, 1'b1, 64'h42, 5'd7, 1'b1, 4'b1111);
        cycle();
        drive(1'b0, 3'd0, 1'b0, 64'h0, 5'd0, 1'b0, 4'b0000);
        check("divz_exc",  wb_exc,  2'b10);
        check("divz_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("divz_we",   wb_we,   1'b0);
        cycle();
        check("divz_nzcv", nzcv_q,    4'b0110);
        check("divz_cnt",  exc_count, 2'd1);

        // Illegal opcodes, counter saturates at 3.
        drive(1'b1, 3'd5, 1'b0, 64'h77, 5'd8, 1'b1, 4'b1000);
        cycle();
        drive(1'b0, 3'd0, 1'b0, 64'h0, 5'd0, 1'b0, 4'b0000);
        check("ill_exc",  wb_exc,  2'b01);
        check("ill_data", wb_data, 64'h0);
        check("ill_we",   wb_we,   1'b0);
        cycle();
        check("ill_cnt2", exc_count, 2'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd5, 1'b0, 64'h1, 5'd2, 1'b1, 4'b0001);
            cycle();
        end
        drive(1'b0, 3'd0, 1'b0, 64'h0, 5'd0, 1'b0, 4'b0000);
        cycle();
        check("sat_cnt",  exc_count, 2'd3);
        check("sat_nzcv", nzcv_q,    4'b0110);

        // Classification table, one instruction at a time.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].bz, vecs[i].c, 5'(i), 1'b0, 4'b0000);
            cycle();
            drive(1'b0, 3'd0, 1'b0, 64'h0, 5'd0, 1'b0, 4'b0000);
            check($sformatf("vec%0d_exc", i),  wb_exc,  vecs[i].exp_exc);
            check($sformatf("vec%0d_data", i), wb_data, vecs[i].exp_data);
            check($sformatf("vec%0d_we", i),   wb_we,   vecs[i].exp_we);
            cycle();
        end

        // Reset with two entries buffered and wb_ready high.
        wb_ready = 1'b0;
        drive(1'b1, 3'd6, 1'b0, 64'h1, 5'd1, 1'b1, 4'b0000);
        cycle();
        drive(1'b1, 3'd0, 1'b0, 64'h2, 5'd2, 1'b1, 4'b1001);
        cycle();
        drive(1'b0, 3'd0, 1'b0, 64'h0, 5'd0, 1'b0, 4'b0000);
        check("mid_full", in_ready, 1'b0);
        rst = 1'b1; wb_ready = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_wb_valid", wb_valid,  1'b0);
        check("mid_nzcv",     nzcv_q,    4'b0000);
        check("mid_cnt",      exc_count, 2'd0);
        cycle();
        check("mid_after_cnt", exc_count, 2'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            wb_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, {$urandom, $urandom},
                  5'($urandom), 1'($urandom), 4'($urandom));
            cycle();
        end
        rst = 1'b0; wb_ready = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 64'h0, 5'd0, 1'b0, 4'b0000);
        repeat (3) cycle();
        check("final_empty", wb_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
